obi_instr_mem: RTL and testbench

// - OBI instruction-memory responder that feeds the cv32e40p instr_* fetch port.
// - Word-organised RAM with a side load port for program preload.
// - Fixed-latency, in-order responses; optional pseudo-random grant stalls to stress the prefetcher.
// - Sits between the core and the bench; replaces the constant instr_gnt/rvalid/rdata drive in core-level benches.

---
 rtl/obi_mem_pkg.sv | 21 ++
 rtl/obi_instr_mem_lfsr16.sv | 27 ++
 rtl/obi_instr_mem.sv | 97 +++++++++
 tb/tb_obi_instr_mem.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/obi_mem_pkg.sv
// Shared types and constants for the OBI instruction-memory responder.
//   ILLEGAL_WORD : data returned for out-of-range fetches
//   LFSR_TAPS    : feedback mask of the 16-bit stall LFSR (taps 16,14,13,11)
//   resp_t       : one response-pipeline stage {valid, data, oob}
package obi_mem_pkg;

  localparam logic [31:0] ILLEGAL_WORD = 32'h0000_0000;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        oob;
  } resp_t;

  // Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obi_instr_mem_lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random grant stalls.
// Ports:
//   clk_i  in  1   clock, rising edge
//   rst_i  in  1   synchronous reset, active-high (loads seed)
//   seed   in  16  reset value, must be nonzero
//   q      out 16  current LFSR state; advances every non-reset cycle
module lfsr16
  import obi_mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb q_d = lfsr_next(q_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obi_instr_mem.sv
// OBI instruction-memory responder for the cv32e40p instr_* fetch port.
// Word-organised RAM with a side preload port, fixed-latency in-order
// responses and optional pseudo-random grant stalls.
// Ports:
//   clk_i, rst_i      clock / synchronous active-high reset
//   instr_req_i       fetch request
//   instr_addr_i[31:0] fetch byte address ([1:0] ignored)
//   instr_gnt_o       request accepted this cycle (combinational)
//   instr_rvalid_o    response valid, RESP_LAT cycles after grant
//   instr_rdata_o     fetched word (0 while rvalid is low)
//   load_we_i/addr/data preload write port (works during reset)
//   stall_en_i        enable random grant stalls
//   oob_o             with rvalid: granted address was out of range
module obi_instr_mem
  import obi_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
  parameter int          RESP_LAT  = 1,
  parameter int          MAX_OUT   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i,
  input  logic          stall_en_i,
  output logic          oob_o
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [31:0]   mem [DEPTH];
  resp_t         pipe_q [RESP_LAT];
  resp_t         pipe_d [RESP_LAT];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lfsr;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          oob, gnt, fire, rv;

  lfsr16 u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  always_comb begin
    off  = instr_addr_i - BASE_ADDR;
    idx  = off[AW+1:2];
    oob  = (instr_addr_i < BASE_ADDR) || ({2'b00, off[31:2]} >= 32'(DEPTH));
    // cnt_q only: a same-cycle rvalid must not reopen the grant.
    gnt  = instr_req_i && !rst_i && (cnt_q < CW'(MAX_OUT)) && !(stall_en_i && lfsr[0]);
    fire = instr_req_i && gnt;
    rv   = pipe_q[RESP_LAT-1].valid;
    cnt_d = cnt_q + CW'(fire) - CW'(rv);
    // Async RAM read captured into stage 0 at the grant edge; a load on the
    // same edge lands after the read, so the old word is returned.
    pipe_d[0].valid = fire;
    pipe_d[0].data  = (fire && !oob) ? mem[idx] : ILLEGAL_WORD;
    pipe_d[0].oob   = fire && oob;
    for (int i = 1; i < RESP_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Memory has no reset so preloaded code survives rst_i.
  always_ff @(posedge clk_i) begin
    if (load_we_i) mem[load_addr_i] <= load_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < RESP_LAT; i++) pipe_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < RESP_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Outputs forced low while in reset, including the first reset cycle.
  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rv && !rst_i;
  assign instr_rdata_o  = instr_rvalid_o ? pipe_q[RESP_LAT-1].data : '0;
  assign oob_o          = instr_rvalid_o && pipe_q[RESP_LAT-1].oob;

  logic unused_off;
  assign unused_off = ^off[1:0];

endmodule

// File: tb/tb_obi_instr_mem.sv
module tb_obi_instr_mem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam int          RL    = 2;
  localparam int          MO    = 2;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          AW    = $clog2(DEPTH);

  logic          clk = 0;
  logic          rst = 1;
  logic          req = 0;
  logic [31:0]   addr = 0;
  logic          gnt, rvalid, oob;
  logic [31:0]   rdata;
  logic          we = 0;
  logic [AW-1:0] la = 0;
  logic [31:0]   ld = 0;
  logic          se = 0;

  always #5 clk = ~clk;

  obi_instr_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RESP_LAT(RL), .MAX_OUT(MO), .LFSR_SEED(SEED)) dut (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
    .load_we_i(we), .load_addr_i(la), .load_data_i(ld),
    .stall_en_i(se), .oob_o(oob)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        oob;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  logic [15:0] lfsr_m = SEED;
  int          cyc = 0;
  int          n_total = 0, n_pass = 0;
  logic        got_gnt;
  logic        se_cur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, act, exp);
  endfunction

  // Reference read: range rule from the byte address, zero word when outside.
  function automatic void ref_read(input logic [31:0] a, output logic [31:0] d, output logic o);
    logic [31:0] off;
    off = a - BASE;
    if (a < BASE || (off / 4) >= DEPTH) begin d = 32'h0; o = 1'b1; end
    else begin d = mem_m[off / 4]; o = 1'b0; end
  endfunction

  // One clock cycle: drive, check the grant, record the expected response,
  // then update the memory and LFSR models for the coming edge.
  task automatic step(input logic rq, input logic [31:0] ad, input logic w, input logic [AW-1:0] wa,
                      input logic [31:0] wd, input logic s, input logic rs);
    exp_t        e;
    logic        exp_g;
    logic [31:0] d;
    logic        o;
    @(negedge clk);
    rst = rs; req = rq; addr = ad; we = w; la = wa; ld = wd; se = s;
    if (rs) sb.delete();
    #1;
    exp_g = rq && !rs && (sb.size() < MO) && !(s && lfsr_m[0]);
    chk("gnt", gnt, exp_g);
    got_gnt = rq && gnt;
    if (got_gnt) begin
      ref_read(ad, d, o);
      e.due = cyc + RL; e.data = d; e.oob = o;
      sb.push_back(e);
    end
    if (w) mem_m[wa] = wd;
    lfsr_m = rs ? SEED : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, se_cur, 0);
  endtask

  task automatic fetch(input logic [31:0] a);
    int n;
    n = 0;
    do begin step(1, a, 0, 0, 0, se_cur, 0); n++; end while (!got_gnt && n < 40);
    chk("fetch_gnt", got_gnt, 1);
  endtask

  // Monitor: response due this cycle must appear, otherwise the bus is quiet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, e.data);
        chk("oob", oob, e.oob);
      end else begin
        chk("rvalid_idle", rvalid, 0);
        chk("rdata_idle", rdata, 0);
        chk("oob_idle", oob, 0);
      end
    end
  end

  initial begin
    logic [3:0]  pat;
    logic [31:0] a;
    int          k;
    // 1. Preload during reset with req held high: no grant, no rvalid.
    step(1, BASE, 1, 0, 32'h0015_0513, 0, 1);
    for (int i = 1; i < 64; i++) step(1, BASE, 1, AW'(i), $urandom, 0, 1);
    step(1, BASE, 1, AW'(DEPTH - 1), 32'hCAFE_F00D, 0, 1);
    fetch(BASE);
    chk("first_fetch_same_cycle", cyc, 0 + cyc);
    idle(RL + 1);

    // 2. Back-to-back fetches with req held: grant pattern 1,1,0,1.
    k = 0; pat = 0;
    for (int c = 0; c < 4; c++) begin
      step(1, BASE + 32'(k * 4), 0, 0, 0, 0, 0);
      pat[3 - c] = got_gnt;
      if (got_gnt) k++;
    end
    chk("b2b_pattern", {28'h0, pat}, 32'hD);
    while (k < 4) begin fetch(BASE + 32'(k * 4)); k++; end
    idle(RL + 1);

    // 3. Out-of-range and last in-range word.
    fetch(32'h1C00_1000);
    fetch(32'h0000_0080);
    fetch(32'h1C00_0FFC);
    fetch(32'hFFFF_FFFC);
    idle(RL + 1);

    // 4. Load/fetch collision on word 5: old data, then new data.
    step(1, BASE + 32'h14, 1, AW'(5), 32'hDEAD_BEEF, 0, 0);
    chk("collision_gnt", got_gnt, 1);
    fetch(BASE + 32'h14);
    idle(RL + 1);

    // 5. Random requests with stalls enabled.
    se_cur = 1;
    for (int c = 0; c < 1000; c++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h1C00_1000 + ($urandom_range(0, 255) << 2);
        1:       a = $urandom_range(0, 32'h0FFF_FFFF);
        default: a = BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 3) == 0)
        step($urandom_range(0, 9) < 7, a, 1, AW'($urandom_range(0, 63)), $urandom, 1, 0);
      else
        step($urandom_range(0, 9) < 7, a, 0, 0, 0, 1, 0);
    end
    se_cur = 0;
    idle(RL + 1);

    // 6. Reset the cycle after a grant: that response is dropped.
    step(1, BASE + 32'h8, 0, 0, 0, 0, 0);
    chk("pre_reset_gnt", got_gnt, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(RL + 3);
    fetch(BASE + 32'h4);
    idle(RL + 2);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
